// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the integer pipeline (port 0)
// and the branch/compare unit (port 1), with a registered per-port result channel.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data
);

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t            state_r;
  logic [DATA_W-1:0] result_r;
  logic              owner_r;
  logic              last_r;
  logic              rsp0_valid_r;
  logic              rsp1_valid_r;

  logic              handshake_s;
  logic              can_accept_s;
  logic              gnt_valid_s;
  logic              gnt_port_s;

  // Accept handshake of the current owner and decide whether a new grant may issue
  always_comb begin
    handshake_s  = 1'b0;
    can_accept_s = 1'b0;
    if (owner_r == 1'b0) begin
      handshake_s = rsp0_valid_r & rsp0_ready;
    end else begin
      handshake_s = rsp1_valid_r & rsp1_ready;
    end
    case (state_r)
      IDLE:    can_accept_s = 1'b1;
      RESP:    can_accept_s = handshake_s;
      default: can_accept_s = 1'b0;
    endcase
  end

  // Round-robin pick: on a tie the port not granted last time wins
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_port_s  = 1'b0;
    if (can_accept_s) begin
      if (req0_valid && req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_port_s  = ~last_r;
      end else if (req0_valid) begin
        gnt_valid_s = 1'b1;
        gnt_port_s  = 1'b0;
      end else if (req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_port_s  = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = 1'b0;
      end
    end else begin
      gnt_valid_s = 1'b0;
      gnt_port_s  = 1'b0;
    end
  end

  // Route the granted request to the ALU; idle bus is driven to zero
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_op     = {OP_W{1'b0}};
    alu_a      = {DATA_W{1'b0}};
    alu_b      = {DATA_W{1'b0}};
    if (gnt_valid_s && (gnt_port_s == 1'b0)) begin
      req0_ready = 1'b1;
      alu_op     = req0_op;
      alu_a      = req0_a;
      alu_b      = req0_b;
    end else if (gnt_valid_s && (gnt_port_s == 1'b1)) begin
      req1_ready = 1'b1;
      alu_op     = req1_op;
      alu_a      = req1_a;
      alu_b      = req1_b;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // IDLE/RESP controller; a new grant in RESP replaces the drained result without a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      result_r     <= {DATA_W{1'b0}};
      owner_r      <= 1'b0;
      last_r       <= 1'b1;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else if (gnt_valid_s) begin
      state_r      <= RESP;
      result_r     <= alu_result;
      owner_r      <= gnt_port_s;
      last_r       <= gnt_port_s;
      rsp0_valid_r <= (gnt_port_s == 1'b0);
      rsp1_valid_r <= (gnt_port_s == 1'b1);
    end else if (handshake_s) begin
      state_r      <= IDLE;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      state_r      <= state_r;
      rsp0_valid_r <= rsp0_valid_r;
      rsp1_valid_r <= rsp1_valid_r;
    end
  end

  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_data  = result_r;
  assign rsp1_data  = result_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: per-cycle vector table plus an
// asynchronous-reset-mid-response sequence, with a small ADD/SUB ALU model.
module tb_alu_share_arbiter;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] NOP = 4'b0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;

  int tests  = 0;
  int failed = 0;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data)
  );

  always #5 clk = ~clk;

  // Reference ALU behind the arbiter
  always_comb begin
    case (alu_op)
      ADD:     alu_result = alu_a + alu_b;
      SUB:     alu_result = alu_a - alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    logic v0; logic [3:0] op0; logic [31:0] a0; logic [31:0] b0;
    logic v1; logic [3:0] op1; logic [31:0] a1; logic [31:0] b1;
    logic rr0; logic rr1;
    logic e_rdy0; logic e_rdy1; logic [3:0] e_op; logic [31:0] e_a; logic [31:0] e_b;
    logic e_rv0; logic e_rv1; logic [31:0] e_d;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                              input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic rr0, input logic rr1,
                              input logic e_rdy0, input logic e_rdy1, input logic [3:0] e_op,
                              input logic [31:0] e_a, input logic [31:0] e_b,
                              input logic e_rv0, input logic e_rv1, input logic [31:0] e_d);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr0 = rr0; v.rr1 = rr1;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_op = e_op; v.e_a = e_a; v.e_b = e_b;
    v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_d = e_d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    rsp0_ready = v.rr0; rsp1_ready = v.rr1;
  endtask

  initial begin
    // Cycle-by-cycle script starting from reset (last granted = port 1)
    //               v0   op0  a0     b0     v1   op1  a1     b1     rr0  rr1  rdy0 rdy1 eop  ea     eb     rv0  rv1  ed
    vecs[0]  = mk(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    vecs[1]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0, SUB, 32'd9, 32'd4, 1'b0, 1'b0, 32'd0);
    vecs[2]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b0, 32'd5);
    vecs[3]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0, SUB, 32'd9, 32'd4, 1'b0, 1'b1, 32'd3);
    vecs[4]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b0, 32'd5);
    vecs[5]  = mk(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b1, 32'd3);
    vecs[6]  = mk(1'b0, NOP, 32'd0, 32'd0, 1'b1, ADD, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0);
    vecs[7]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b1, 32'd6);
    vecs[8]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b1, 32'd6);
    vecs[9]  = mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b1, 32'd6);
    vecs[10] = mk(1'b1, SUB, 32'd9, 32'd4, 1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, SUB, 32'd9, 32'd4, 1'b0, 1'b1, 32'd6);
    vecs[11] = mk(1'b0, NOP, 32'd0, 32'd0, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b0, 32'd5);
    vecs[12] = mk(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b1, 32'd3);
    vecs[13] = mk(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    reset = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("reset_rsp0_data", rsp0_data, 32'd0);
    check("reset_rsp1_data", rsp1_data, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_rdy0});
      check($sformatf("v%0d_req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_rdy1});
      check($sformatf("v%0d_alu_op", i), {28'd0, alu_op}, {28'd0, vecs[i].e_op});
      check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_a);
      check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].e_b);
      check($sformatf("v%0d_rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].e_rv0});
      check($sformatf("v%0d_rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].e_rv1});
      if (vecs[i].e_rv0) check($sformatf("v%0d_rsp0_data", i), rsp0_data, vecs[i].e_d);
      if (vecs[i].e_rv1) check($sformatf("v%0d_rsp1_data", i), rsp1_data, vecs[i].e_d);
    end

    // Reset arriving mid-response: valids drop at once, port 0 wins the next tie
    @(negedge clk);
    drive(mk(1'b1, SUB, 32'd9, 32'd4, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0,
             1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
    #1;
    check("rst_seq_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("rst_seq_rsp0_valid_pre", {31'd0, rsp0_valid}, 32'd1);
    check("rst_seq_rsp0_data_pre", rsp0_data, 32'd5);
    #1;
    reset = 1'b1;
    #1;
    check("rst_seq_rsp0_valid_async", {31'd0, rsp0_valid}, 32'd0);
    check("rst_seq_rsp1_valid_async", {31'd0, rsp1_valid}, 32'd0);
    check("rst_seq_rsp0_data_async", rsp0_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(1'b1, SUB, 32'd9, 32'd4, 1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b1,
             1'b0, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
    #1;
    check("rst_seq_contest_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("rst_seq_contest_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rst_seq_post_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("rst_seq_post_rsp0_data", rsp0_data, 32'd5);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
